// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants for the FIFO read-side stream master and its skid buffer.
// FWFT encodings are common to the FIFO, its stimulus models and this reader.
package fifo_rd_stream_pkg;

    localparam int SKID_DEPTH = 3;
    // Also wide enough to hold an occupancy count of 0..SKID_DEPTH.
    localparam int SKID_PTR_W = 2;

    localparam int FWFT_STD        = 0;
    localparam int FWFT_SHOW_AHEAD = 1;

    typedef logic [SKID_PTR_W-1:0] skid_ptr_t;

    function automatic skid_ptr_t skid_ptr_inc(input skid_ptr_t p);
        return (p == skid_ptr_t'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Three-entry register FIFO that absorbs read latency ahead of the stream port.
// A push into a full buffer without a simultaneous pop is dropped and flagged.
module fifo_rd_skid
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output skid_ptr_t         count,
    output logic [DATA_W-1:0] head_data,
    output logic              overflow
);

    logic [DATA_W-1:0] mem_q [SKID_DEPTH];
    logic [DATA_W-1:0] mem_d [SKID_DEPTH];
    skid_ptr_t         wr_ptr_q, wr_ptr_d;
    skid_ptr_t         rd_ptr_q, rd_ptr_d;
    skid_ptr_t         count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              do_push, do_pop;

    always_comb begin
        do_pop     = pop && (count_q != '0);
        // A full buffer still accepts a push when the head leaves in the same cycle.
        do_push    = push && ((count_q != skid_ptr_t'(SKID_DEPTH)) || do_pop);
        wr_ptr_d   = do_push ? skid_ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = do_pop  ? skid_ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d    = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
        overflow_d = overflow_q || (push && !do_push);
    end

    generate
        for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
            always_comb begin
                mem_d[gi] = (do_push && (wr_ptr_q == skid_ptr_t'(gi))) ? push_data : mem_q[gi];
            end

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    mem_q[gi] <= '0;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];
    assign overflow  = overflow_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side master: drains a FIFO read port into a valid/ready stream.
// Reads are issued only from registered occupancy, so m_ready never reaches rd_en.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int BYTE_WIDTH  = 8,
    parameter int FWFT        = 0,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                    rd_clk,
    input  logic                    rd_rstn,
    output logic                    rd_en,
    input  logic                    rd_valid,
    input  logic [BYTE_WIDTH*8-1:0] rd_data,
    input  logic                    rd_empty,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [BYTE_WIDTH*8-1:0] m_data,
    output logic [COUNT_WIDTH-1:0]  beat_count,
    output logic                    idle,
    output logic                    overflow
);

    localparam int DATA_W = BYTE_WIDTH * 8;

    skid_ptr_t              skid_count;
    logic                   push, pop;
    logic                   inflight_q, inflight_d;
    logic [COUNT_WIDTH-1:0] beat_count_q, beat_count_d;

    generate
        if (FWFT == FWFT_SHOW_AHEAD) begin : g_show_ahead
            logic unused_rd_valid;
            assign unused_rd_valid = rd_valid;

            always_comb begin
                rd_en      = rd_rstn && !rd_empty && (skid_count != skid_ptr_t'(SKID_DEPTH));
                push       = rd_en && !rd_empty;
                inflight_d = 1'b0;
            end
        end else begin : g_std
            // Reserve a slot for the read already in flight so returning data always fits.
            always_comb begin
                rd_en      = rd_rstn && !rd_empty
                             && (({1'b0, skid_count} + {2'b00, inflight_q}) <= 3'd2);
                push       = rd_valid;
                inflight_d = rd_en;
            end
        end
    endgenerate

    fifo_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (rd_clk),
        .rstn      (rd_rstn),
        .push      (push),
        .push_data (rd_data),
        .pop       (pop),
        .count     (skid_count),
        .head_data (m_data),
        .overflow  (overflow)
    );

    always_comb begin
        m_valid      = (skid_count != '0);
        pop          = m_valid && m_ready;
        beat_count_d = pop ? beat_count_q + 1'b1 : beat_count_q;
        idle         = rd_empty && (skid_count == '0) && !inflight_q;
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_rstn) begin
            inflight_q   <= 1'b0;
            beat_count_q <= '0;
        end else begin
            inflight_q   <= inflight_d;
            beat_count_q <= beat_count_d;
        end
    end

    assign beat_count = beat_count_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO model feeds three instances
// (standard, show-ahead, 4-bit beat counter); a scoreboard checks every beat.
module tb_fifo_rd_stream;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    int          sel;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic        f_empty;
    logic        m_ready;

    logic        rd_en_i   [3];
    logic        m_valid_i [3];
    logic [63:0] m_data_i  [3];
    logic [31:0] bc_i      [3];
    logic        idle_i    [3];
    logic        ovf_i     [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int FW = (gi == 1) ? 1 : 0;
            localparam int CW = (gi == 2) ? 4 : 32;
            logic [CW-1:0] bc;

            fifo_rd_stream #(
                .BYTE_WIDTH  (8),
                .FWFT        (FW),
                .COUNT_WIDTH (CW)
            ) u_dut (
                .rd_clk     (clk),
                .rd_rstn    (rstn),
                .rd_en      (rd_en_i[gi]),
                .rd_valid   (rd_valid && (sel == gi)),
                .rd_data    (rd_data),
                .rd_empty   (f_empty || (sel != gi)),
                .m_valid    (m_valid_i[gi]),
                .m_ready    (m_ready && (sel == gi)),
                .m_data     (m_data_i[gi]),
                .beat_count (bc),
                .idle       (idle_i[gi]),
                .overflow   (ovf_i[gi])
            );

            assign bc_i[gi] = 32'(bc);
        end
    endgenerate

    int          checks = 0;
    int          errors = 0;
    logic [63:0] fq [$];
    logic [63:0] exp_q [$];
    int          rdy_mode;
    int          cyc, beats, issued;
    int          first_en, first_mv, first_beat, last_beat;
    logic        prev_hold;
    logic [63:0] prev_md;
    logic        gap_mv;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic refresh();
        f_empty = (fq.size() == 0);
        if (sel == 1) rd_data = f_empty ? 64'h0 : fq[0];
    endtask

    // One clock: sample and score at the falling edge, update the FIFO model after the rising edge.
    task automatic cycle();
        logic        en, mv, do_rd;
        logic [63:0] md, e;
        logic [63:0] popped = '0;
        @(negedge clk);
        en = rd_en_i[sel];
        mv = m_valid_i[sel];
        md = m_data_i[sel];
        cyc++;
        if (rstn) begin
            chk("occupancy", 64'((issued - beats) > 3), 64'd0);
            if (prev_hold && mv) chk("hold", md, prev_md);
            if (en && first_en < 0) first_en = cyc;
            if (mv && first_mv < 0) first_mv = cyc;
            if (mv && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", md, e);
                end
                beats++;
                if (first_beat < 0) first_beat = cyc;
                last_beat = cyc;
            end
            issued += int'(en);
        end
        prev_hold = rstn && mv && !m_ready;
        prev_md   = md;
        do_rd     = en && (fq.size() != 0);
        if (do_rd) popped = fq.pop_front();
        @(posedge clk);
        #1;
        if (sel != 1) begin
            rd_valid = do_rd;
            if (do_rd) rd_data = popped;
        end else begin
            rd_valid = 1'b0;
        end
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'b0;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        refresh();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        cycle();
        rstn       = 1'b1;
        issued     = 0;
        beats      = 0;
        first_en   = -1;
        first_mv   = -1;
        first_beat = -1;
        last_beat  = -1;
        prev_hold  = 1'b0;
    endtask

    task automatic wr(input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            fq.push_back(base + 64'(i));
            exp_q.push_back(base + 64'(i));
        end
        refresh();
    endtask

    task automatic run(input int target, input int budget, input string tag);
        int k = 0;
        while (beats < target && k < budget) begin
            cycle();
            k++;
        end
        chk(tag, 64'(beats), 64'(target));
    endtask

    task automatic select(input int s);
        sel      = s;
        rd_valid = 1'b0;
        refresh();
    endtask

    initial begin
        rstn     = 1'b0;
        sel      = 0;
        rd_valid = 1'b0;
        rd_data  = '0;
        m_ready  = 1'b0;
        rdy_mode = 1;
        f_empty  = 1'b1;
        cyc      = 0;

        // Reset state
        do_reset();
        chk("rst_m_valid", 64'(m_valid_i[0]), 64'd0);
        chk("rst_m_data",  m_data_i[0],       64'd0);
        chk("rst_beat_cnt", 64'(bc_i[0]),     64'd0);
        chk("rst_overflow", 64'(ovf_i[0]),    64'd0);
        chk("rst_rd_en",   64'(rd_en_i[0]),   64'd0);
        chk("rst_idle",    64'(idle_i[0]),    64'd1);
        $display("reset: checks=%0d errors=%0d", checks, errors);

        // 16 words, always ready
        rdy_mode = 0;
        m_ready  = 1'b1;
        wr(16, 64'd0);
        run(16, 100, "t1_beats");
        chk("t1_latency", 64'(first_mv - first_en), 64'd2);
        chk("t1_b2b", 64'(last_beat - first_beat), 64'd15);
        repeat (3) cycle();
        chk("t1_beat_cnt", 64'(bc_i[0]), 64'd16);
        chk("t1_idle", 64'(idle_i[0]), 64'd1);
        chk("t1_overflow", 64'(ovf_i[0]), 64'd0);
        $display("t1 fwft0 stream: beats=%0d errors=%0d", beats, errors);

        // Backpressure for 10 cycles
        rdy_mode = 1;
        do_reset();
        wr(8, 64'h0002_0000_0000_0000);
        repeat (10) cycle();
        chk("t2_reads", 64'(issued), 64'd3);
        chk("t2_m_valid", 64'(m_valid_i[0]), 64'd1);
        chk("t2_head", m_data_i[0], 64'h0002_0000_0000_0000);
        rdy_mode = 0;
        m_ready  = 1'b1;
        run(8, 100, "t2_beats");
        chk("t2_overflow", 64'(ovf_i[0]), 64'd0);
        $display("t2 backpressure: issued=%0d beats=%0d errors=%0d", issued, beats, errors);

        // Random ready, both FWFT modes
        for (int s = 0; s < 2; s++) begin
            select(s);
            rdy_mode = 1;
            do_reset();
            rdy_mode = 2;
            wr(1000, 64'h0003_0000_0000_0000 + (64'(s) << 32));
            run(1000, 6000, "t3_beats");
            chk("t3_left", 64'(exp_q.size()), 64'd0);
            chk("t3_overflow", 64'(ovf_i[s]), 64'd0);
            chk("t3_beat_cnt", 64'(bc_i[s]), 64'd1000);
            $display("t3 random ready fwft=%0d: beats=%0d errors=%0d", s, beats, errors);
        end

        // FIFO runs dry mid-stream, refilled 20 cycles later
        select(0);
        rdy_mode = 0;
        do_reset();
        wr(8, 64'h0004_0000_0000_0000);
        run(8, 100, "t4_first");
        gap_mv = 1'b0;
        repeat (20) begin
            cycle();
            gap_mv = gap_mv | m_valid_i[0];
        end
        chk("t4_gap_m_valid", 64'(gap_mv), 64'd0);
        chk("t4_gap_idle", 64'(idle_i[0]), 64'd1);
        wr(8, 64'h0004_0000_0000_0008);
        run(16, 100, "t4_resume");
        $display("t4 drain/resume: beats=%0d errors=%0d", beats, errors);

        // Reset with two entries buffered and one read in flight
        rdy_mode = 1;
        do_reset();
        wr(3, 64'h0005_0000_0000_0000);
        repeat (3) cycle();
        chk("t5_pre_issued", 64'(issued), 64'd3);
        chk("t5_pre_m_valid", 64'(m_valid_i[0]), 64'd1);
        do_reset();
        chk("t5_m_valid", 64'(m_valid_i[0]), 64'd0);
        chk("t5_beat_cnt", 64'(bc_i[0]), 64'd0);
        chk("t5_rd_en", 64'(rd_en_i[0]), 64'd0);
        chk("t5_idle", 64'(idle_i[0]), 64'd1);
        exp_q.delete();
        rdy_mode = 0;
        repeat (5) cycle();
        chk("t5_no_emit", 64'(beats), 64'd0);
        wr(4, 64'h0005_0000_0000_0100);
        run(4, 100, "t5_after");
        $display("t5 reset flush: beats=%0d errors=%0d", beats, errors);

        // 4-bit beat counter wraps
        select(2);
        rdy_mode = 0;
        do_reset();
        wr(20, 64'h0006_0000_0000_0000);
        run(20, 200, "t6_beats");
        repeat (2) cycle();
        chk("t6_beat_cnt", 64'(bc_i[2]), 64'd4);
        chk("t6_overflow", 64'(ovf_i[2]), 64'd0);
        $display("t6 counter wrap: beat_count=%0d errors=%0d", bc_i[2], errors);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
